// File: rtl/stream_serializer.sv
// stream_serializer: takes one wide word of LANES packed elements from a
// ready/valid FIFO stream and replays it downstream one element per handshake.
// The element that ends the word is flagged with o_output_last.
// Optional build macro STREAM_SERIALIZER_MSB_FIRST_EN sends the elements in
// reverse order: lane count-1 first, lane 0 last.
// Handshake timing, latency and count clamping are the same in both builds.
module stream_serializer #(
    parameter int ELEM_WIDTH = 8,
    parameter int LANES      = 4,
    parameter int LANE_BIT   = $clog2(LANES),
    parameter int CNT_BIT    = $clog2(LANES + 1)
) (
    input  logic                        i_clk,
    input  logic                        i_reset,
    output logic                        o_input_ready,
    input  logic                        i_input_valid,
    input  logic [ELEM_WIDTH*LANES-1:0] i_input_data,
    input  logic [CNT_BIT-1:0]          i_input_count,
    input  logic                        i_output_ready,
    output logic                        o_output_valid,
    output logic [ELEM_WIDTH-1:0]       o_output_data,
    output logic                        o_output_last
);

    typedef enum logic {
        EMPTY = 1'b0,
        BUSY  = 1'b1
    } state_t;

    state_t                      state, state_next;
    logic [ELEM_WIDTH*LANES-1:0] word_data;
    logic [CNT_BIT-1:0]          word_count, count_next, count_clamped;
    logic [LANE_BIT-1:0]         lane_idx, lane_next, out_lane;
    logic [CNT_BIT-1:0]          lane_ext;
    logic                        load, rd_en, wr_en, is_last;
    logic [ELEM_WIDTH-1:0]       lane_array [LANES];

    // Split the held word into lanes so that one element can be picked by index.
    for (genvar k = 0; k < LANES; k++) begin : g_lane
        assign lane_array[k] = word_data[k*ELEM_WIDTH +: ELEM_WIDTH];
    end

    // lane_idx counts the elements already sent in this word.
    // The physical lane depends on the build order.
    assign lane_ext = CNT_BIT'(lane_idx);
`ifdef STREAM_SERIALIZER_MSB_FIRST_EN
    assign out_lane = LANE_BIT'(word_count - CNT_BIT'(1) - lane_ext);
`else
    assign out_lane = lane_idx;
`endif
    assign o_output_data = lane_array[out_lane];

    // A count of zero or a count above LANES means a full word.
    always_comb begin
        count_clamped = i_input_count;
        if (i_input_count == '0 || i_input_count > CNT_BIT'(LANES)) begin
            count_clamped = CNT_BIT'(LANES);
        end
    end

    // Next-state logic and handshakes. Input-ready rises in the same cycle that
    // the last element is taken, so back-to-back words have no bubble between them.
    always_comb begin
        state_next     = state;
        lane_next      = lane_idx;
        count_next     = word_count;
        load           = 1'b0;
        o_output_valid = (state == BUSY);
        is_last        = (state == BUSY) && (lane_ext == word_count - CNT_BIT'(1));
        o_output_last  = is_last;
        rd_en          = i_output_ready & o_output_valid;
        o_input_ready  = (state == EMPTY) | (rd_en & is_last);
        wr_en          = o_input_ready & i_input_valid;
        case (state)
            EMPTY: begin
                if (wr_en) begin
                    state_next = BUSY;
                    lane_next  = '0;
                    count_next = count_clamped;
                    load       = 1'b1;
                end
            end
            BUSY: begin
                if (rd_en) begin
                    if (is_last) begin
                        lane_next = '0;
                        if (wr_en) begin
                            count_next = count_clamped;
                            load       = 1'b1;
                        end else begin
                            state_next = EMPTY;
                        end
                    end else begin
                        lane_next = lane_idx + LANE_BIT'(1);
                    end
                end
            end
            default: begin
                state_next = EMPTY;
            end
        endcase
    end

    // Control state register. A reset drops any word that is only partly sent.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state      <= EMPTY;
            lane_idx   <= '0;
            word_count <= CNT_BIT'(LANES);
        end else begin
            state      <= state_next;
            lane_idx   <= lane_next;
            word_count <= count_next;
        end
    end

    // The word payload is only meaningful while BUSY, so it has no reset.
    always_ff @(posedge i_clk) begin
        if (load) begin
            word_data <= i_input_data;
        end
    end

endmodule

// File: tb/tb_stream_serializer.sv
// Testbench for stream_serializer (default parameters, 4 lanes of 8 bits).
// The same macro STREAM_SERIALIZER_MSB_FIRST_EN selects the vector set for the
// reversed-order build.
module tb_stream_serializer;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic        o_input_ready;
    logic        i_input_valid;
    logic [31:0] i_input_data;
    logic [2:0]  i_input_count;
    logic        i_output_ready;
    logic        o_output_valid;
    logic [7:0]  o_output_data;
    logic        o_output_last;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        rst;
        logic        iv;
        logic [31:0] idata;
        logic [2:0]  icnt;
        logic        ordy;
        logic        ev;
        logic [7:0]  edata;
        logic        elast;
        logic        eir;
    } vec_t;

    vec_t vecs[$];

    stream_serializer dut (
        .i_clk          (i_clk),
        .i_reset        (i_reset),
        .o_input_ready  (o_input_ready),
        .i_input_valid  (i_input_valid),
        .i_input_data   (i_input_data),
        .i_input_count  (i_input_count),
        .i_output_ready (i_output_ready),
        .o_output_valid (o_output_valid),
        .o_output_data  (o_output_data),
        .o_output_last  (o_output_last)
    );

    always #5 i_clk = ~i_clk;

    // One row is one clock cycle: the inputs driven, and the outputs expected before the edge.
    function automatic void add(input logic rst, input logic iv, input logic [31:0] d,
                                input logic [2:0] c, input logic ordy, input logic ev,
                                input logic [7:0] ed, input logic el, input logic eir);
        vec_t v;
        v.rst = rst; v.iv = iv; v.idata = d; v.icnt = c; v.ordy = ordy;
        v.ev = ev; v.edata = ed; v.elast = el; v.eir = eir;
        vecs.push_back(v);
    endfunction

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic apply_stimulus(input vec_t v, input int row);
        @(negedge i_clk);
        i_reset        = v.rst;
        i_input_valid  = v.iv;
        i_input_data   = v.idata;
        i_input_count  = v.icnt;
        i_output_ready = v.ordy;
        #1;
        check_output($sformatf("row%0d valid", row), 32'(o_output_valid), 32'(v.ev));
        check_output($sformatf("row%0d last", row), 32'(o_output_last), 32'(v.elast));
        check_output($sformatf("row%0d in_ready", row), 32'(o_input_ready), 32'(v.eir));
        if (v.ev) begin
            check_output($sformatf("row%0d data", row), 32'(o_output_data), 32'(v.edata));
        end
    endtask

    task automatic do_reset();
        @(negedge i_clk);
        i_reset = 1'b1; i_input_valid = 1'b0; i_input_data = '0;
        i_input_count = '0; i_output_ready = 1'b0;
        @(negedge i_clk);
        @(negedge i_clk);
        i_reset = 1'b0;
    endtask

    initial begin
        logic [7:0] got [$];
        logic [7:0] exp_seq [4];
        bit         done;

        i_reset = 1'b1; i_input_valid = 1'b0; i_input_data = '0;
        i_input_count = '0; i_output_ready = 1'b0;

`ifdef STREAM_SERIALIZER_MSB_FIRST_EN
        // Three-lane word sent in reverse order.
        add(0, 1, 32'h44332211, 3, 1, 0, 8'h00, 0, 1);
        add(0, 0, 32'h0,        0, 1, 1, 8'h33, 0, 0);
        add(0, 0, 32'h0,        0, 1, 1, 8'h22, 0, 0);
        add(0, 0, 32'h0,        0, 1, 1, 8'h11, 1, 1);
        add(0, 0, 32'h0,        0, 1, 0, 8'h00, 0, 1);
        // Full word with a stall on the second element.
        add(0, 1, 32'h44332211, 4, 1, 0, 8'h00, 0, 1);
        add(0, 0, 32'h0,        0, 1, 1, 8'h44, 0, 0);
        add(0, 0, 32'h0,        0, 0, 1, 8'h33, 0, 0);
        add(0, 0, 32'h0,        0, 1, 1, 8'h33, 0, 0);
        add(0, 0, 32'h0,        0, 1, 1, 8'h22, 0, 0);
        add(0, 0, 32'h0,        0, 1, 1, 8'h11, 1, 1);
        add(0, 0, 32'h0,        0, 1, 0, 8'h00, 0, 1);
        exp_seq = '{8'h04, 8'h03, 8'h02, 8'h01};
`else
        // Single word, downstream always ready.
        add(0, 1, 32'h44332211, 4, 1, 0, 8'h00, 0, 1);
        add(0, 0, 32'h0,        0, 1, 1, 8'h11, 0, 0);
        add(0, 0, 32'h0,        0, 1, 1, 8'h22, 0, 0);
        add(0, 0, 32'h0,        0, 1, 1, 8'h33, 0, 0);
        add(0, 0, 32'h0,        0, 1, 1, 8'h44, 1, 1);
        add(0, 0, 32'h0,        0, 1, 0, 8'h00, 0, 1);
        // Back-to-back words, input valid held.
        add(0, 1, 32'h44332211, 4, 1, 0, 8'h00, 0, 1);
        add(0, 1, 32'hDDCCBBAA, 4, 1, 1, 8'h11, 0, 0);
        add(0, 1, 32'hDDCCBBAA, 4, 1, 1, 8'h22, 0, 0);
        add(0, 1, 32'hDDCCBBAA, 4, 1, 1, 8'h33, 0, 0);
        add(0, 1, 32'hDDCCBBAA, 4, 1, 1, 8'h44, 1, 1);
        add(0, 0, 32'h0,        0, 1, 1, 8'hAA, 0, 0);
        add(0, 0, 32'h0,        0, 1, 1, 8'hBB, 0, 0);
        add(0, 0, 32'h0,        0, 1, 1, 8'hCC, 0, 0);
        add(0, 0, 32'h0,        0, 1, 1, 8'hDD, 1, 1);
        add(0, 0, 32'h0,        0, 1, 0, 8'h00, 0, 1);
        // count=2
        add(0, 1, 32'h44332211, 2, 1, 0, 8'h00, 0, 1);
        add(0, 0, 32'h0,        0, 1, 1, 8'h11, 0, 0);
        add(0, 0, 32'h0,        0, 1, 1, 8'h22, 1, 1);
        // count=0 is treated as a full word
        add(0, 1, 32'h44332211, 0, 1, 0, 8'h00, 0, 1);
        add(0, 0, 32'h0,        0, 1, 1, 8'h11, 0, 0);
        add(0, 0, 32'h0,        0, 1, 1, 8'h22, 0, 0);
        add(0, 0, 32'h0,        0, 1, 1, 8'h33, 0, 0);
        add(0, 0, 32'h0,        0, 1, 1, 8'h44, 1, 1);
        // count=1
        add(0, 1, 32'h44332211, 1, 1, 0, 8'h00, 0, 1);
        add(0, 0, 32'h0,        0, 1, 1, 8'h11, 1, 1);
        add(0, 0, 32'h0,        0, 1, 0, 8'h00, 0, 1);
        // Stall three cycles on lane 1; input activity during the stall is ignored.
        add(0, 1, 32'h44332211, 4, 1, 0, 8'h00, 0, 1);
        add(0, 0, 32'h0,        0, 1, 1, 8'h11, 0, 0);
        add(0, 0, 32'h0,        0, 0, 1, 8'h22, 0, 0);
        add(0, 1, 32'hDEADBEEF, 2, 0, 1, 8'h22, 0, 0);
        add(0, 1, 32'hDEADBEEF, 2, 0, 1, 8'h22, 0, 0);
        add(0, 0, 32'h0,        0, 1, 1, 8'h22, 0, 0);
        add(0, 0, 32'h0,        0, 1, 1, 8'h33, 0, 0);
        add(0, 0, 32'h0,        0, 1, 1, 8'h44, 1, 1);
        add(0, 0, 32'h0,        0, 1, 0, 8'h00, 0, 1);
        // Reset after 0x22 pops, then a new word.
        add(0, 1, 32'h44332211, 4, 1, 0, 8'h00, 0, 1);
        add(0, 0, 32'h0,        0, 1, 1, 8'h11, 0, 0);
        add(0, 0, 32'h0,        0, 1, 1, 8'h22, 0, 0);
        add(1, 0, 32'h0,        0, 0, 1, 8'h33, 0, 0);
        add(0, 1, 32'h88776655, 4, 1, 0, 8'h00, 0, 1);
        add(0, 0, 32'h0,        0, 1, 1, 8'h55, 0, 0);
        add(0, 0, 32'h0,        0, 1, 1, 8'h66, 0, 0);
        add(0, 0, 32'h0,        0, 1, 1, 8'h77, 0, 0);
        add(0, 0, 32'h0,        0, 1, 1, 8'h88, 1, 1);
        add(0, 0, 32'h0,        0, 1, 0, 8'h00, 0, 1);
        // count=7 (above LANES) is clamped to 4
        add(0, 1, 32'h44332211, 7, 1, 0, 8'h00, 0, 1);
        add(0, 0, 32'h0,        0, 1, 1, 8'h11, 0, 0);
        add(0, 0, 32'h0,        0, 1, 1, 8'h22, 0, 0);
        add(0, 0, 32'h0,        0, 1, 1, 8'h33, 0, 0);
        add(0, 0, 32'h0,        0, 1, 1, 8'h44, 1, 1);
        add(0, 0, 32'h0,        0, 1, 0, 8'h00, 0, 1);
        exp_seq = '{8'h01, 8'h02, 8'h03, 8'h04};
`endif

        do_reset();
        // Reset state, before any stimulus.
        #1;
        check_output("reset valid", 32'(o_output_valid), 32'd0);
        check_output("reset last", 32'(o_output_last), 32'd0);
        check_output("reset in_ready", 32'(o_input_ready), 32'd1);

        foreach (vecs[i]) begin
            apply_stimulus(vecs[i], i);
        end

        // Alternating downstream ready: collect one word within a bounded window.
        do_reset();
        @(negedge i_clk);
        i_input_valid = 1'b1; i_input_data = 32'h04030201; i_input_count = 3'd4;
        i_output_ready = 1'b0;
        #1;
        check_output("alt in_ready", 32'(o_input_ready), 32'd1);
        @(negedge i_clk);
        i_input_valid = 1'b0;
        done = 1'b0;
        for (int cyc = 0; cyc < 20 && !done; cyc++) begin
            if (cyc != 0) @(negedge i_clk);
            i_output_ready = cyc[0];
            #1;
            if (o_output_valid && i_output_ready) begin
                got.push_back(o_output_data);
                if (o_output_last) done = 1'b1;
            end
        end
        check_output("alt done", 32'(done), 32'd1);
        check_output("alt count", 32'(got.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < got.size()) begin
                check_output($sformatf("alt elem%0d", i), 32'(got[i]), 32'(exp_seq[i]));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
